rr_ring_arbiter: RTL and testbench
==================================

Name: rr_ring_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Rotating priority is held as a one-hot ring pointer, the same rotate-left one-hot structure as the team's ring counter.
- The pointer advances only when a grant ends, never free-running.
- Sits between requesting masters and a shared datapath; it provides a registered one-hot grant, a grant index and a starvation-bounding hold limit.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive cycles one requester may keep the grant while others are waiting (1..255).
- IDX_W, $clog2(N), width of gnt_idx (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- gnt  output  N  registered one-hot grant, or all-zero.
- gnt_valid  output  1  high iff gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the granted bit; 0 when gnt_valid is low.
- ptr  output  N  one-hot priority ring pointer; the highest-priority requester for the next arbitration.
- preempt  output  1  one-cycle pulse in the cycle the grant changes due to MAX_HOLD expiry.

Behaviour:
- **Reset (rst=1 at posedge):**
  - gnt=0, gnt_valid=0, gnt_idx=0, preempt=0, hold_cnt=0, state=IDLE.
  - ptr=one-hot bit N-1 (4'b1000 for N=4).
  - Reset dominates everything, including mid-grant; the next cycle is an IDLE arbitration.
- **Search order:** from the ptr position upward with wrap, i.e. p, p+1, ..., N-1, 0, ..., p-1. The first set req bit wins.
- **State IDLE:**
  - If req==0: stay in IDLE; outputs zero.
  - Else: at the next edge, gnt=onehot(winner), gnt_idx=winner, state=GRANT, hold_cnt=1.
  - Latency from req rising to gnt is 1 cycle.
- **State GRANT, granted index g:**
  - **Release (req[g]=0):**
    - ptr <= onehot((g+1) mod N).
    - Search from g+1 over req with bit g masked.
    - If there is a winner w: gnt switches directly to w at the next edge, with no idle bubble; hold_cnt=1.
    - If there is no winner: gnt=0, state=IDLE.
  - **Expiry (req[g]=1, hold_cnt==MAX_HOLD, and any other req bit set):**
    - Forced rotation exactly as on release (g masked, ptr <= g+1).
    - preempt=1 for the one cycle in which the new gnt first appears.
  - **Hold (otherwise):** gnt unchanged; hold_cnt increments, saturating at MAX_HOLD.
  - If MAX_HOLD is reached with no other requester, the grant continues. Preemption fires in the first cycle another request appears.
- **Invariants:**
  - gnt is always one-hot or zero and is never combinationally derived from req.
  - ptr is always exactly one-hot.
  - ptr is unchanged in IDLE and during holds.
  - Requests from non-granted requesters never disturb an active grant before release or expiry.
- **Simultaneous events:**
  - Release and expiry in the same cycle are treated as release; preempt=0.
  - A requester that drops and re-raises req in the same cycle it is released is not re-granted ahead of others (it is masked for that search).
- **Width rules:** hold_cnt is $clog2(MAX_HOLD+1) bits, unsigned, saturating.

Decomposition:
- **Package rr_arb_pkg:**
  - state enum {IDLE, GRANT}.
  - Function rotl1(onehot): rotate left by one with wrap.
  - Function onehot2idx(onehot) returning IDX_W bits.
- **Sub-module rr_ring_pick:** purely combinational.
  - Inputs: req, ptr, mask. Outputs: winner one-hot and found.
  - Implemented by a double-width request vector with priority select.
- The top level holds the FSM, hold counter, ptr register and output registers.

Test Plan:
- Reset then req=4'b1111 held: grants cycle 3,0,1,2,3,... Each grant lasts MAX_HOLD=8 cycles, preempt pulses at every switch, ptr follows 0001,0010,0100,1000.
- req=4'b0001 raised one cycle after reset: gnt=0001 one cycle later, gnt_idx=0. Drop req: gnt=0 next cycle, ptr=0010, state IDLE.
- req=4'b0110 with each requester dropping after 3 cycles: gnt=0010 (3 cycles) then directly 0100 with no zero cycle; preempt never asserts.
- req[2] held alone for 20 cycles: gnt=0100 throughout, no preempt. At cycle 21 raise req[0]: the next cycle gives gnt=0001, preempt=1, ptr=1000.
- Assert rst mid-grant with gnt=0100: next cycle gnt=0, ptr=1000. With req=1111 still asserted, the cycle after gives gnt=1000.
- Every cycle across all tests: check gnt one-hot-or-zero, gnt_valid==|gnt, ptr one-hot.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and one-hot helpers for the round-robin ring arbiter.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int unsigned MAX_N     = 16;
    localparam int unsigned MAX_IDX_W = 4;

    // Rotate the low n bits of a one-hot vector left by one, wrapping bit n-1 to bit 0.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] oh, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) r[(i + 1) % n] = oh[i];
        end
        return r;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_ring_pick.sv
// Combinational rotating-priority pick: first set bit of (req & mask) at or above ptr, with wrap.
module rr_ring_pick
    import rr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    input  logic [N-1:0] mask,
    output logic [N-1:0] winner,
    output logic         found
);

    logic [N-1:0]   rm;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] win2;
    logic           seen;

    // Lower copy is eligible from ptr upward; the upper copy supplies the wrapped tail.
    always_comb begin
        rm    = req & mask;
        dbl   = {rm, rm};
        win2  = '0;
        seen  = 1'b0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ptr[i]) seen = 1'b1;
            if (seen && !found && dbl[i]) begin
                win2[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && dbl[i + N]) begin
                win2[i + N] = 1'b1;
                found       = 1'b1;
            end
        end
        winner = win2[N-1:0] | win2[2*N-1:N];
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer, registered grant and a hold-limit preemption.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     ptr,
    output logic             preempt
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t                 state;
    logic [HW-1:0]          hold_cnt;
    logic [N-1:0]           pick_ptr;
    logic [N-1:0]           pick_mask;
    logic [N-1:0]           win;
    logic                   found;
    logic [MAX_N-1:0]       gnt_rot_w;
    logic [N-1:0]           gnt_rot;
    logic [MAX_IDX_W-1:0]   win_idx_w;
    logic                   release_g;
    logic                   expire_g;

    assign gnt_rot_w = rotl1(MAX_N'(gnt), N);
    assign gnt_rot   = gnt_rot_w[N-1:0];
    assign win_idx_w = onehot2idx(MAX_N'(win));

    // On release/expiry the search starts just past the current holder, which is masked out.
    assign pick_ptr  = (state == IDLE) ? ptr : gnt_rot;
    assign pick_mask = (state == IDLE) ? '1  : ~gnt;

    assign release_g = (state == GRANT) && ((req & gnt) == '0);
    assign expire_g  = (state == GRANT) && ((req & gnt) != '0)
                       && (hold_cnt == HW'(MAX_HOLD)) && ((req & ~gnt) != '0);

    rr_ring_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .mask   (pick_mask),
        .winner (win),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= {1'b1, {(N-1){1'b0}}};
        end else begin
            case (state)
                IDLE: begin
                    preempt <= 1'b0;
                    if (found) begin
                        gnt       <= win;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= win_idx_w[IDX_W-1:0];
                        hold_cnt  <= HW'(1);
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_g || expire_g) begin
                        ptr     <= gnt_rot;
                        preempt <= expire_g;
                        if (found) begin
                            gnt      <= win;
                            gnt_idx  <= win_idx_w[IDX_W-1:0];
                            hold_cnt <= HW'(1);
                        end else begin
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_idx   <= '0;
                            hold_cnt  <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        preempt <= 1'b0;
                        if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter: per-cycle comparison against an index-based reference model.
module tb_rr_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDX_W    = $clog2(N);

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     ptr;
    logic             preempt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: granted index (-1 = none), pointer index, hold length, preempt flag.
    int m_g    = -1;
    int m_p    = N - 1;
    int m_hold = 0;
    bit m_pre  = 1'b0;

    rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .ptr       (ptr),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [N-1:0] r, input int start, input int masked);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != masked && r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        bit rel, exp_f;
        if (rst) begin
            m_g = -1; m_p = N - 1; m_hold = 0; m_pre = 1'b0;
        end else if (m_g < 0) begin
            m_pre = 1'b0;
            w = search(req, m_p, -1);
            if (w >= 0) begin m_g = w; m_hold = 1; end
        end else begin
            rel   = !req[m_g];
            exp_f = req[m_g] && (m_hold == MAX_HOLD) && ((req & ~(N'(1) << m_g)) != '0);
            if (rel || exp_f) begin
                m_pre = exp_f && !rel;
                m_p   = (m_g + 1) % N;
                w     = search(req, m_p, m_g);
                if (w >= 0) begin m_g = w; m_hold = 1; end
                else begin m_g = -1; m_hold = 0; end
            end else begin
                m_pre = 1'b0;
                if (m_hold < MAX_HOLD) m_hold++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt", 32'(gnt), (m_g < 0) ? 32'd0 : 32'(N'(1) << m_g));
            check("model_idx", 32'(gnt_idx), (m_g < 0) ? 32'd0 : 32'(m_g));
            check("model_ptr", 32'(ptr), 32'(N'(1) << m_p));
            check("model_preempt", 32'(preempt), 32'(m_pre));
            check("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("inv_valid", 32'(gnt_valid), 32'(gnt != '0));
            check("inv_ptr_onehot", 32'($onehot(ptr)), 32'd1);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0;
        step(2);
        chk_en = 1'b1;
        rst = 1'b0;

        // Full load: 3,0,1,2,3 with preemption at every switch
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ptr", 32'(ptr), 32'b1000);
        check("rst_valid", 32'(gnt_valid), 32'd0);
        req = 4'b1111;
        step();
        check("full_first_gnt", 32'(gnt), 32'b1000);
        check("full_first_idx", 32'(gnt_idx), 32'd3);
        step(8);
        check("full_sw0_gnt", 32'(gnt), 32'b0001);
        check("full_sw0_pre", 32'(preempt), 32'd1);
        check("full_sw0_ptr", 32'(ptr), 32'b0001);
        step();
        check("full_pre_pulse", 32'(preempt), 32'd0);
        step(7);
        check("full_sw1_gnt", 32'(gnt), 32'b0010);
        check("full_sw1_ptr", 32'(ptr), 32'b0010);
        step(16);
        check("full_sw3_gnt", 32'(gnt), 32'b1000);
        check("full_sw3_ptr", 32'(ptr), 32'b1000);

        // Single requester, release to idle
        do_reset();
        step();
        req = 4'b0001;
        step();
        check("single_gnt", 32'(gnt), 32'b0001);
        check("single_idx", 32'(gnt_idx), 32'd0);
        req = 4'b0000;
        step();
        check("single_rel_gnt", 32'(gnt), 32'd0);
        check("single_rel_ptr", 32'(ptr), 32'b0010);

        // Back-to-back release with no bubble
        req = 4'b0110;
        step(3);
        check("b2b_first", 32'(gnt), 32'b0010);
        req = 4'b0100;
        step();
        check("b2b_second", 32'(gnt), 32'b0100);
        check("b2b_no_pre", 32'(preempt), 32'd0);
        step(2);
        req = 4'b0000;
        step();
        check("b2b_idle", 32'(gnt), 32'd0);

        // Lone holder past MAX_HOLD, then a late competitor
        do_reset();
        req = 4'b0100;
        step(20);
        check("lone_gnt", 32'(gnt), 32'b0100);
        check("lone_no_pre", 32'(preempt), 32'd0);
        req = 4'b0101;
        step();
        check("late_gnt", 32'(gnt), 32'b0001);
        check("late_pre", 32'(preempt), 32'd1);
        check("late_ptr", 32'(ptr), 32'b1000);

        // Reset mid-grant
        do_reset();
        req = 4'b0100;
        step();
        check("mid_pre_rst", 32'(gnt), 32'b0100);
        req = 4'b1111; rst = 1'b1;
        step();
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_ptr", 32'(ptr), 32'b1000);
        rst = 1'b0;
        step();
        check("mid_after_gnt", 32'(gnt), 32'b1000);

        // Release coinciding with hold limit counts as release
        do_reset();
        req = 4'b1001;
        step(8);
        check("relexp_hold", 32'(gnt), 32'b1000);
        req = 4'b0001;
        step();
        check("relexp_gnt", 32'(gnt), 32'b0001);
        check("relexp_no_pre", 32'(preempt), 32'd0);

        // Drop-and-reraise holder is masked on its own release
        do_reset();
        req = 4'b0011;
        step();
        check("mask_first", 32'(gnt), 32'b0001);
        req = 4'b0010;
        step();
        check("mask_switch", 32'(gnt), 32'b0010);
        req = 4'b0011;
        step(3);
        check("mask_keep", 32'(gnt), 32'b0010);
        req = 4'b0000;
        step(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
